gamepad_pmod_rx_multi: RTL

Parametrised receiver for the gamepad PMOD serial link (pmod_clk / pmod_data / pmod_latch), the successor to the fixed two-pad decoder used by the gamepad PMOD demo top. It supports NUM_PADS controllers of 12 buttons each and synchronises the asynchronous PMOD pins. It validates frame length, reports per-pad presence and emits one-cycle pressed/released event vectors. Sits between the ui_in pins and the demo's game/display logic.

---
 rtl/gamepad_pmod_rx_multi.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/gamepad_pmod_rx_multi.sv
// Multi-pad gamepad PMOD receiver: synchronises the serial link, checks frame length and reports
// buttons, presence and press/release events. Optional watchdog under GAMEPAD_WATCHDOG_EN.
module gamepad_pmod_rx_multi #(
   parameter int unsigned NUM_PADS    = 2,
   parameter int unsigned WDOG_CYCLES = 1_000_000
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     pmod_clk,
   input  logic                     pmod_data,
   input  logic                     pmod_latch,
   output logic [12*NUM_PADS-1:0]   buttons,
   output logic [NUM_PADS-1:0]      present,
   output logic [12*NUM_PADS-1:0]   pressed,
   output logic [12*NUM_PADS-1:0]   released,
   output logic                     frame_valid,
   output logic                     frame_err,
   output logic                     wdog_fired
);

   localparam int unsigned FRAME_BITS = 12 * NUM_PADS;
   localparam int unsigned CNT_MAX    = FRAME_BITS + 1;
   localparam int unsigned CNT_W      = $clog2(CNT_MAX + 1);

   if (NUM_PADS < 1 || NUM_PADS > 4) begin : g_bad_pads
      $error("NUM_PADS must be 1..4");
   end
   if (WDOG_CYCLES < 2) begin : g_bad_wdog
      $error("WDOG_CYCLES must be at least 2");
   end

   logic [2:0]            sync1;
   logic [2:0]            sync2;
   logic                  hist_clk;
   logic                  hist_latch;
   logic                  clk_rise;
   logic                  latch_rise;
   logic                  data_s;
   logic [FRAME_BITS-1:0] shift_reg;
   logic [CNT_W-1:0]      cnt;
   logic                  commit;
   logic [FRAME_BITS-1:0] new_buttons;
   logic [NUM_PADS-1:0]   new_present;

   // Two-stage synchronisers for {latch, data, clk} plus edge history for clk and latch
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync1      <= '0;
         sync2      <= '0;
         hist_clk   <= 1'b0;
         hist_latch <= 1'b0;
      end else begin
         sync1      <= {pmod_latch, pmod_data, pmod_clk};
         sync2      <= sync1;
         hist_clk   <= sync2[0];
         hist_latch <= sync2[2];
      end
   end

   assign clk_rise   = sync2[0] & ~hist_clk;
   assign latch_rise = sync2[2] & ~hist_latch;
   assign data_s     = sync2[1];
   assign commit     = latch_rise && (cnt == CNT_W'(FRAME_BITS));

   // Shift register and saturating bit counter; a latch edge takes priority over a clock edge
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         shift_reg <= '0;
         cnt       <= '0;
      end else if (latch_rise) begin
         cnt <= '0;
      end else if (clk_rise) begin
         shift_reg <= {shift_reg[FRAME_BITS-2:0], data_s};
         if (cnt != CNT_W'(CNT_MAX)) begin
            cnt <= cnt + CNT_W'(1);
         end
      end
   end

   // An unconnected pad reads all-ones and is reported as absent with no buttons
   always_comb begin
      new_buttons = '0;
      new_present = '0;
      for (int k = 0; k < NUM_PADS; k++) begin
         new_present[k] = (shift_reg[12*k +: 12] != 12'hFFF);
         new_buttons[12*k +: 12] = new_present[k] ? shift_reg[12*k +: 12] : 12'h000;
      end
   end

`ifdef GAMEPAD_WATCHDOG_EN
   localparam int unsigned WD_W = $clog2(WDOG_CYCLES);

   logic [WD_W-1:0] wdog_cnt;
   logic            wdog_done;
   logic            wdog_hit;

   assign wdog_hit = (wdog_cnt == WD_W'(WDOG_CYCLES - 1)) && !wdog_done;

   // Cycles since the last commit; fires once per silent period
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wdog_cnt  <= '0;
         wdog_done <= 1'b0;
      end else if (commit) begin
         wdog_cnt  <= '0;
         wdog_done <= 1'b0;
      end else begin
         if (wdog_cnt != WD_W'(WDOG_CYCLES - 1)) begin
            wdog_cnt <= wdog_cnt + WD_W'(1);
         end
         if (wdog_hit) begin
            wdog_done <= 1'b1;
         end
      end
   end
`else
   assign wdog_fired = 1'b0;
`endif

   // Registered outputs; event vectors and flags are single-cycle pulses
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         buttons     <= '0;
         present     <= '0;
         pressed     <= '0;
         released    <= '0;
         frame_valid <= 1'b0;
         frame_err   <= 1'b0;
`ifdef GAMEPAD_WATCHDOG_EN
         wdog_fired  <= 1'b0;
`endif
      end else begin
         pressed     <= '0;
         released    <= '0;
         frame_valid <= 1'b0;
         frame_err   <= 1'b0;
`ifdef GAMEPAD_WATCHDOG_EN
         wdog_fired  <= 1'b0;
`endif
         if (commit) begin
            buttons     <= new_buttons;
            present     <= new_present;
            pressed     <= new_buttons & ~buttons;
            released    <= buttons & ~new_buttons;
            frame_valid <= 1'b1;
         end else begin
            if (latch_rise) begin
               frame_err <= 1'b1;
            end
`ifdef GAMEPAD_WATCHDOG_EN
            if (wdog_hit) begin
               buttons    <= '0;
               present    <= '0;
               released   <= buttons;
               wdog_fired <= 1'b1;
            end
`endif
         end
      end
   end

endmodule
